// File: rtl/ap_si_wall_pipe_if.sv
// Operand/result handshake bundle for ap_si_wall_pipe.
// The master side drives operands and out_ready. The slave side is the pipeline.
interface ap_si_wall_pipe_if #(
   parameter int DW = 12
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [DW-1:0]   muld;
   logic signed [DW-1:0]   mulr;
   logic                   apx_en;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [2*DW-1:0] res;
   logic [1:0]             occ;

   modport master (
      output in_valid, muld, mulr, apx_en, out_ready,
      input  in_ready, out_valid, res, occ
   );

   modport slave (
      input  in_valid, muld, mulr, apx_en, out_ready,
      output in_ready, out_valid, res, occ
   );
endinterface

// File: rtl/ap_si_wall_pipe.sv
// Three-stage signed multiplier: operand capture, carry-save reduction, final add.
// Optional output accumulator with acc_clr port, enabled by macro AP_SI_WALL_PIPE_ACC_EN.
module ap_si_wall_pipe #(
   parameter int DW       = 12,
   parameter int APX_COLS = 0
) (
   input logic clk,
   input logic rst,
`ifdef AP_SI_WALL_PIPE_ACC_EN
   input logic acc_clr,
`endif
   ap_si_wall_pipe_if.slave pif
);
   localparam int W = 2 * DW;
`ifdef AP_SI_WALL_PIPE_ACC_EN
   localparam int RW = W + 4;
`else
   localparam int RW = W;
`endif
   localparam logic [W-1:0] APX_MASK = {W{1'b1}} << APX_COLS;

   logic          v1, v2, v3;
   logic          a1, a2;
   logic [DW-1:0] m1, r1;
   logic [W-1:0]  s2, c2;
   logic [RW-1:0] r3, r3_nxt;
   logic [W-1:0]  ws, wc, prod;

   assign pif.in_ready  = !(v3 && !pif.out_ready);
   assign pif.out_valid = v3;
   assign pif.res       = r3[W-1:0];
   assign pif.occ       = 2'(v1) + 2'(v2) + 2'(v3);

   // Sign-extending both operands to 2*DW makes every row a plain add modulo 2^(2*DW),
   // so the most negative operand needs no correction row.
   always_comb begin
      logic [W-1:0] mx, rx, pp, ns;
      mx = {{DW{m1[DW-1]}}, m1};
      rx = {{DW{r1[DW-1]}}, r1};
      pp = '0;
      ns = '0;
      ws = '0;
      wc = '0;
      for (int unsigned i = 0; i < W; i++) begin
         pp = rx[i] ? (mx << i) : '0;
         ns = ws ^ wc ^ pp;
         wc = ((ws & wc) | (ws & pp) | (wc & pp)) << 1;
         ws = ns;
      end
   end

   // Clearing the low bits of the exact two's-complement sum is a floor toward -inf.
   assign prod = (s2 + c2) & (a2 ? APX_MASK : {W{1'b1}});

`ifdef AP_SI_WALL_PIPE_ACC_EN
   logic          clr1, clr2;
   logic [RW-1:0] acc, base;

   // S3 only loads when it is empty or being consumed, so the base already
   // includes the beat that leaves in the same cycle.
   always_comb begin
      base   = (v3 && pif.out_ready) ? r3 : acc;
      r3_nxt = (clr2 ? '0 : base) + {{(RW-W){prod[W-1]}}, prod};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         clr1 <= 1'b0;
         clr2 <= 1'b0;
      end else begin
         if (v3 && pif.out_ready)
            acc <= r3;
         if (pif.in_ready) begin
            clr1 <= acc_clr;
            clr2 <= clr1;
         end
      end
   end
`else
   assign r3_nxt = prod;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         a1 <= 1'b0;
         a2 <= 1'b0;
         m1 <= '0;
         r1 <= '0;
         s2 <= '0;
         c2 <= '0;
         r3 <= '0;
      end else if (pif.in_ready) begin
         v1 <= pif.in_valid;
         m1 <= pif.muld;
         r1 <= pif.mulr;
         a1 <= pif.apx_en;
         v2 <= v1;
         a2 <= a1;
         s2 <= ws;
         c2 <= wc;
         v3 <= v2;
         if (v2)
            r3 <= r3_nxt;
      end
   end
endmodule

// File: tb/tb_ap_si_wall_pipe.sv
// Directed self-checking bench for ap_si_wall_pipe (DW=12, APX_COLS=4).
// Covers latency, approximate mode, streaming, backpressure and mid-flight reset.
module tb_ap_si_wall_pipe;
   localparam int DW  = 12;
   localparam int APX = 4;

   logic clk = 1'b0;
   logic rst;
`ifdef AP_SI_WALL_PIPE_ACC_EN
   logic acc_clr;
`endif
   int nchk = 0;
   int nbad = 0;

   typedef struct {
      int     a;
      int     b;
      bit     apx;
      bit     clr;
      longint exp;
   } vec_t;

   vec_t tbl [11] = '{
      '{-2048, -2048, 1'b0, 1'b1,  4194304},
      '{  100,   -37, 1'b1, 1'b1,    -3712},
      '{  100,   -37, 1'b0, 1'b1,    -3700},
      '{ 2047,  2047, 1'b0, 1'b1,  4190209},
      '{-2048,  2047, 1'b0, 1'b1, -4192256},
      '{    7,    -1, 1'b1, 1'b1,      -16},
      '{   15,     1, 1'b1, 1'b1,        0},
      '{   33,     1, 1'b1, 1'b1,       32},
      '{    3,     4, 1'b0, 1'b1,       12},
      '{    5,     6, 1'b0, 1'b0,       42},
      '{   -2,     7, 1'b0, 1'b0,       28}
   };

   ap_si_wall_pipe_if #(.DW(DW)) pif ();

   ap_si_wall_pipe #(.DW(DW), .APX_COLS(APX)) dut (
      .clk    (clk),
      .rst    (rst),
`ifdef AP_SI_WALL_PIPE_ACC_EN
      .acc_clr(acc_clr),
`endif
      .pif    (pif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      nchk++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit vld);
      pif.in_valid = vld;
      pif.muld     = DW'(tbl[i].a);
      pif.mulr     = DW'(tbl[i].b);
      pif.apx_en   = tbl[i].apx;
`ifdef AP_SI_WALL_PIPE_ACC_EN
      acc_clr      = tbl[i].clr;
`endif
   endtask

   // Offers tbl[base..base+n-1] back to back; out_ready drops for stall_len cycles from stall_at.
   task automatic run_stream(input int base, input int n, input int stall_at,
                             input int stall_len, input string nm);
      int     ni = 0;
      int     oi = 0;
      int     cyc = 0;
      int     fo = -1;
      int     lo = -1;
      longint held = 0;
      bit     acc_in;
      while (oi < n && cyc < 100) begin
         pif.out_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
         if (ni < n) drive(base + ni, 1'b1);
         else pif.in_valid = 1'b0;
         #1;
         if (stall_len > 0 && cyc == stall_at) held = pif.res;
         if (stall_len > 0 && cyc > stall_at && cyc < stall_at + stall_len) begin
            chk({nm, "_hold_res"}, pif.res, held);
            chk({nm, "_hold_vld"}, longint'(pif.out_valid), 1);
         end
         if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
            chk({nm, "_stall_rdy"}, longint'(pif.in_ready), 0);
            chk({nm, "_stall_occ"}, longint'(pif.occ), 3);
         end
         if (n >= 8 && cyc == 5)
            chk({nm, "_occ_full"}, longint'(pif.occ), 3);
         acc_in = pif.in_valid && pif.in_ready;
         if (pif.out_valid && pif.out_ready) begin
            chk($sformatf("%s_res%0d", nm, oi), pif.res, tbl[base + oi].exp);
            if (fo < 0) fo = cyc;
            lo = cyc;
            oi++;
         end
         tick();
         if (acc_in) ni++;
         cyc++;
      end
      pif.in_valid  = 1'b0;
      pif.out_ready = 1'b1;
      chk({nm, "_count"}, oi, n);
      chk({nm, "_span"}, lo - fo, n - 1 + stall_len);
      tick();
      chk({nm, "_drain_occ"}, longint'(pif.occ), 0);
      chk({nm, "_drain_vld"}, longint'(pif.out_valid), 0);
   endtask

   initial begin
      rst           = 1'b1;
      pif.in_valid  = 1'b0;
      pif.out_ready = 1'b1;
      pif.muld      = '0;
      pif.mulr      = '0;
      pif.apx_en    = 1'b0;
`ifdef AP_SI_WALL_PIPE_ACC_EN
      acc_clr       = 1'b1;
`endif
      tick();
      tick();
      rst = 1'b0;
      chk("rst_vld", longint'(pif.out_valid), 0);
      chk("rst_occ", longint'(pif.occ), 0);
      chk("rst_res", pif.res, 0);
      chk("rst_rdy", longint'(pif.in_ready), 1);

      // Single beat: most negative operands, three-cycle latency.
      drive(0, 1'b1);
      tick();
      pif.in_valid = 1'b0;
      chk("lat1_vld", longint'(pif.out_valid), 0);
      tick();
      chk("lat2_vld", longint'(pif.out_valid), 0);
      tick();
      chk("lat3_vld", longint'(pif.out_valid), 1);
      chk("lat3_res", pif.res, tbl[0].exp);
      tick();
      chk("lat_drain_occ", longint'(pif.occ), 0);

      run_stream(1, 2, 0, 0, "apx");
      run_stream(0, 8, 0, 0, "stream");
      run_stream(0, 8, 4, 5, "bp");

      // Reset with three beats in flight; the beat offered during reset must be dropped.
      pif.out_ready = 1'b1;
      for (int i = 3; i < 6; i++) begin
         drive(i, 1'b1);
         tick();
      end
      chk("pre_rst_occ", longint'(pif.occ), 3);
      rst = 1'b1;
      drive(7, 1'b1);
      tick();
      rst = 1'b0;
      pif.in_valid = 1'b0;
      chk("mid_rst_vld", longint'(pif.out_valid), 0);
      chk("mid_rst_occ", longint'(pif.occ), 0);
      chk("mid_rst_res", pif.res, 0);
      chk("mid_rst_rdy", longint'(pif.in_ready), 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("ghost%0d", k), longint'(pif.out_valid), 0);
      end
      run_stream(6, 2, 0, 0, "post_rst");

`ifdef AP_SI_WALL_PIPE_ACC_EN
      run_stream(8, 3, 0, 0, "acc");
`endif

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end
endmodule

// File: doc/ap_si_wall_pipe.md
AP_SI_WALL_PIPE -- requirements
Module: ap_si_wall_pipe

Interface
REQ-001 SHALL have parameter DW, default 12, operand width in bits, legal range 4..32.
REQ-002 SHALL have parameter APX_COLS, default 0, number of low product columns truncated in approximate mode, legal range 0..DW.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port muld  input  DW  signed multiplicand.
REQ-008 SHALL have port mulr  input  DW  signed multiplier.
REQ-009 SHALL have port apx_en  input  1  per-beat approximate-mode select.
REQ-010 SHALL have port out_valid  output  1  result beat offered.
REQ-011 SHALL have port out_ready  input  1  result beat consumed when out_valid and out_ready are both high.
REQ-012 SHALL have port res  output  2*DW  signed result.
REQ-013 SHALL have port occ  output  2  number of beats held in the pipeline, 0..3.

Function
REQ-014 SHALL implement three register stages: S1 captures operands and apx_en; S2 holds the compressed partial-product sum and carry vectors; S3 holds the final-added result driven on res.
REQ-015 SHALL produce res = muld*mulr, two's complement and exact over the full 2*DW bits, when the beat's apx_en is 0 or APX_COLS is 0.
REQ-016 SHALL produce res = floor(muld*mulr / 2^APX_COLS) * 2^APX_COLS, with the low APX_COLS bits zero, when the beat's apx_en is 1.
REQ-017 SHALL deliver out_valid exactly 3 cycles after acceptance when out_ready stays high.
REQ-018 SHALL sustain one accepted beat per cycle with no bubbles while out_ready is high.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready), combinationally; the whole pipeline stalls when S3 is full and not consumed.
REQ-020 SHALL advance bubbles when stalled upstream: an empty stage accepts from the stage before it even while a later stage holds data, provided in_ready is high.
REQ-021 SHALL hold res and out_valid stable while out_valid is high and out_ready is low.
REQ-022 SHALL, when a beat is accepted and another consumed in the same cycle, keep occ unchanged.
REQ-023 SHALL keep beat ordering strictly FIFO; apx_en travels with its own operands.
REQ-024 SHALL return occ to 0 when the pipeline drains; occ never exceeds 3.
REQ-025 SHALL handle the boundary case muld = mulr = -2^(DW-1) with the exact positive result 2^(2*DW-2) and no overflow.

Reset
REQ-026 SHALL, with rst high at a clock edge, clear all stage valid flags, making out_valid 0, occ 0, res 0 and in_ready 1 on the next cycle.
REQ-027 SHALL discard any in-flight beats when reset is asserted mid-operation; no partial result may appear after reset.
REQ-028 SHALL not accept input in a cycle where rst is high.

Configuration
REQ-029 SHALL, with macro AP_SI_WALL_PIPE_ACC_EN defined, add port acc_clr (input, 1 bit) and a 2*DW+4-bit signed accumulator on the output beat.
- res then carries the low 2*DW bits of acc + product.
- Accumulation updates on each out_valid && out_ready handshake.
- acc_clr sampled with the input beat restarts the sum from that beat's product.
- The accumulator resets to 0.
REQ-030 SHALL, without AP_SI_WALL_PIPE_ACC_EN, have no acc_clr port and no accumulator; res is the per-beat product.

Verification
REQ-031 SHALL verify DW=12, apx_en=0: muld=-2048, mulr=-2048 -> res=4194304 after 3 cycles.
REQ-032 SHALL verify DW=12, APX_COLS=4, apx_en=1: muld=100, mulr=-37 -> res=-3712, i.e. exact -3700 floored to a multiple of 16; the same beat with apx_en=0 -> -3700.
REQ-033 SHALL verify a back-to-back stream of 8 beats with out_ready held high -> 8 results on consecutive cycles, in order, with occ=3 in steady state.
REQ-034 SHALL verify backpressure: out_ready low for 5 cycles with a stream offered -> in_ready low after the pipe fills, occ=3, res held stable, no beat lost or duplicated after release.
REQ-035 SHALL verify rst asserted with 3 beats in flight -> next cycle out_valid=0, occ=0; subsequent beats produce only their own results.
REQ-036 SHALL verify, with AP_SI_WALL_PIPE_ACC_EN defined, beats (3,4, acc_clr=1), (5,6), (-2,7) -> res=12, 42, 28.
